// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default geometry, the stereo sample pair type and
// word-select helpers. Used by i2s_transmitter and i2s_receiver.
package i2s_pkg;

  localparam int I2S_WIDTH     = 16;
  localparam int I2S_SCLK_DIV  = 8;
  localparam int I2S_SLOT_BITS = 32;

  typedef struct packed {
    logic [I2S_WIDTH-1:0] l;
    logic [I2S_WIDTH-1:0] r;
  } stereo_sample_t;

  typedef enum logic {
    WS_LEFT  = 1'b0,
    WS_RIGHT = 1'b1
  } ws_e;

  // Standard I2S: ws changes one bit before each slot MSB.
  function automatic ws_e ws_i2s(input int bit_idx, input int slot_bits);
    return ((bit_idx >= slot_bits - 1) && (bit_idx <= 2 * slot_bits - 2)) ? WS_RIGHT : WS_LEFT;
  endfunction

  // Left-justified: ws changes together with each slot MSB.
  function automatic ws_e ws_left_justified(input int bit_idx, input int slot_bits);
    return (bit_idx >= slot_bits) ? WS_RIGHT : WS_LEFT;
  endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-pair handshake between a PCM source (master) and the I2S
// transmitter (slave). A transfer happens on tx_valid && tx_ready.
interface i2s_transmitter_if
  import i2s_pkg::*;
#(
  parameter int WIDTH = I2S_WIDTH
);

  logic [WIDTH-1:0] tx_data_l;
  logic [WIDTH-1:0] tx_data_r;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output tx_data_l,
    output tx_data_r,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data_l,
    input  tx_data_r,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/i2s_clkgen.sv
// I2S bus-master timing: divides mclk into sclk, counts bits in the frame
// and drives ws. Emits strobes that mark the mclk edge on which sclk falls
// (fall_o) and on which a new frame begins (frame_o), plus the bit index that
// becomes current on that edge. Shared by the transmitter and receiver.
// Build option: define I2S_LEFT_JUSTIFIED_EN for left-justified ws timing;
// default is standard I2S with ws leading each slot by one bit.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter  int SCLK_DIV  = I2S_SCLK_DIV,
  parameter  int SLOT_BITS = I2S_SLOT_BITS,
  localparam int DIV_W     = $clog2(SCLK_DIV),
  localparam int BIT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             mclk,
  input  logic             rst,
  output logic             fall_o,
  output logic             frame_o,
  output logic [BIT_W-1:0] bit_nxt_o,
  output logic             sclk_o,
  output logic             ws_o
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sclk_q;
  ws_e              ws_q, ws_d;
  logic             fall;

  // Next-state for the divider and bit counter; a fall event is the wrap of div_cnt.
  always_comb begin
    fall      = (div_cnt_q == DIV_LAST);
    div_cnt_d = fall ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end
`ifdef I2S_LEFT_JUSTIFIED_EN
    ws_d = ws_left_justified(int'(bit_cnt_d), SLOT_BITS);
`else
    ws_d = ws_i2s(int'(bit_cnt_d), SLOT_BITS);
`endif
  end

  // Timing registers; sclk follows the divider so it falls exactly on fall events.
  always_ff @(posedge mclk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      ws_q      <= WS_LEFT;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= (div_cnt_d >= DIV_HALF);
      if (fall) begin
        ws_q <= ws_d;
      end
    end
  end

  assign fall_o    = fall;
  assign frame_o   = fall && (bit_cnt_q == BIT_LAST);
  assign bit_nxt_o = bit_cnt_d;
  assign sclk_o    = sclk_q;
  assign ws_o      = ws_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter (bus master). Accepts stereo pairs into a one-deep holding
// register, loads them into two shift registers at each frame boundary and
// serialises them MSB first onto sd_tx, changing only on sclk falling edges.
// Build option: define I2S_LEFT_JUSTIFIED_EN (handled in i2s_clkgen) for
// left-justified ws timing; data order and handshake are unchanged.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter  int WIDTH     = I2S_WIDTH,
  parameter  int SCLK_DIV  = I2S_SCLK_DIV,
  parameter  int SLOT_BITS = I2S_SLOT_BITS,
  localparam int BIT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic                mclk,
  input  logic                rst,
  i2s_transmitter_if.slave    tx_if,
  output logic                underflow,
  output logic                sclk,
  output logic                ws,
  output logic                sd_tx
);

  logic             fall;
  logic             frame;
  logic [BIT_W-1:0] bit_nxt;

  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d;
  logic [WIDTH-1:0] sh_r_q, sh_r_d;
  logic             sd_tx_q, sd_tx_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] load_l, load_r;
  logic             accept;

  i2s_clkgen #(
    .SCLK_DIV  (SCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .mclk      (mclk),
    .rst       (rst),
    .fall_o    (fall),
    .frame_o   (frame),
    .bit_nxt_o (bit_nxt),
    .sclk_o    (sclk),
    .ws_o      (ws)
  );

  assign accept         = tx_if.tx_valid && !hold_full_q;
  assign tx_if.tx_ready = !hold_full_q;
  // An empty holding register at a frame boundary sends a silent frame.
  assign load_l         = hold_full_q ? hold_l_q : '0;
  assign load_r         = hold_full_q ? hold_r_q : '0;

  // Holding-register handshake, frame load and per-bit shifting.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    sd_tx_d     = sd_tx_q;
    underflow_d = 1'b0;

    // The load consumes the old contents first, so a same-cycle accept is never lost.
    if (frame) begin
      underflow_d = !hold_full_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = tx_if.tx_data_l;
      hold_r_d    = tx_if.tx_data_r;
    end

    // The MSB goes straight to sd_tx at load, so the left shifter starts one bit ahead.
    if (fall) begin
      if (frame) begin
        sd_tx_d = load_l[WIDTH-1];
        sh_l_d  = load_l << 1;
        sh_r_d  = load_r;
      end else if (bit_nxt < BIT_W'(SLOT_BITS)) begin
        sd_tx_d = sh_l_q[WIDTH-1];
        sh_l_d  = sh_l_q << 1;
      end else begin
        sd_tx_d = sh_r_q[WIDTH-1];
        sh_r_d  = sh_r_q << 1;
      end
    end
  end

  // Datapath registers; reset drops any held pair.
  always_ff @(posedge mclk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      // NOTE: data registers are reset too, so the frame after reset is truly zero, not X.
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      sd_tx_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      sd_tx_q     <= sd_tx_d;
      underflow_q <= underflow_d;
    end
  end

  assign sd_tx     = sd_tx_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter (WIDTH=16, SCLK_DIV=8, SLOT_BITS=32).
// The reference model works from elapsed mclk cycles since reset and a table
// of which sample pair belongs to which frame; every output is compared on the
// falling mclk edge. Honours I2S_LEFT_JUSTIFIED_EN for the ws expectation.
module tb_i2s_transmitter;
  import i2s_pkg::*;

  localparam int W          = 16;
  localparam int DIV        = 8;
  localparam int SLOT       = 32;
  localparam int FRAME_BITS = 2 * SLOT;
  localparam int FRAME_CYC  = DIV * FRAME_BITS;
  localparam int MAXF       = 256;

  logic mclk = 1'b0;
  logic rst;
  logic underflow, sclk, ws, sd_tx;

  i2s_transmitter_if #(.WIDTH(W)) tx_if ();

  i2s_transmitter #(
    .WIDTH     (W),
    .SCLK_DIV  (DIV),
    .SLOT_BITS (SLOT)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .tx_if     (tx_if),
    .underflow (underflow),
    .sclk      (sclk),
    .ws        (ws),
    .sd_tx     (sd_tx)
  );

  always #5 mclk = ~mclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // Model state: n = mclk edges since reset released; pair table per frame.
  int             n = 0;
  bit             fr_has [MAXF];
  logic [W-1:0]   fr_l   [MAXF];
  logic [W-1:0]   fr_r   [MAXF];

  // What the bench observed on sd_tx, one 64-bit word per frame.
  logic [63:0]    cap_word;
  logic [63:0]    cap_bits [MAXF];
  bit             cap_done [MAXF];

  bit   accepted;
  int   last_accept_n = 0;
  int   ws_rise_k = -1;
  int   ws_fall_k = -1;
  logic ws_prev = 1'b0;
  int   uf_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit k of frame f as the line should carry it.
  function automatic logic exp_bit(input int f, input int k);
    logic [W-1:0] w;
    int i;
    if (!fr_has[f]) return 1'b0;
    w = (k < SLOT) ? fr_l[f] : fr_r[f];
    i = k % SLOT;
    if (i >= W) return 1'b0;
    return w[W-1-i];
  endfunction

  function automatic logic [63:0] frame_word(input int f);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < FRAME_BITS; k++) w[63-k] = exp_bit(f, k);
    return w;
  endfunction

  function automatic logic exp_ws(input int k);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return k >= SLOT;
`else
    return (k >= SLOT - 1) && (k <= 2 * SLOT - 2);
`endif
  endfunction

  // One mclk cycle: edge, model update, compare on the falling edge.
  task automatic step();
    bit          rdy_before;
    int          f, k;
    logic [4:0]  act, exp;
    rdy_before = !fr_has[n / FRAME_CYC + 1];
    @(posedge mclk);
    accepted = 1'b0;
    if (rst) begin
      n = 0;
      for (int i = 0; i < MAXF; i++) begin
        fr_has[i]   = 1'b0;
        cap_done[i] = 1'b0;
      end
    end else begin
      n++;
      if (tx_if.tx_valid && rdy_before) begin
        f         = n / FRAME_CYC + 1;
        fr_has[f] = 1'b1;
        fr_l[f]   = tx_if.tx_data_l;
        fr_r[f]   = tx_if.tx_data_r;
        accepted  = 1'b1;
        last_accept_n = n;
      end
    end
    @(negedge mclk);
    f   = n / FRAME_CYC;
    k   = (n / DIV) % FRAME_BITS;
    exp = {(n % DIV) >= DIV / 2, exp_ws(k), exp_bit(f, k), !fr_has[f+1],
           (n > 0) && (n % FRAME_CYC == 0) && !fr_has[f]};
    act = {sclk, ws, sd_tx, tx_if.tx_ready, underflow};
    check($sformatf("outputs{sclk,ws,sd,rdy,uf} n=%0d", n), 64'(act), 64'(exp));
    if (n % DIV == DIV / 2) begin
      cap_word[63-k] = sd_tx;
      if (k == FRAME_BITS - 1) begin
        cap_bits[f] = cap_word;
        cap_done[f] = 1'b1;
        check($sformatf("frame_word f=%0d", f), cap_word, frame_word(f));
      end
    end
    if (ws === 1'b1 && ws_prev === 1'b0) ws_rise_k = k;
    if (ws === 1'b0 && ws_prev === 1'b1) ws_fall_k = k;
    ws_prev = ws;
    if (underflow === 1'b1) uf_count++;
  endtask

  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r, output int tgt);
    int cnt;
    cnt = 0;
    tx_if.tx_data_l = l;
    tx_if.tx_data_r = r;
    tx_if.tx_valid  = 1'b1;
    do begin
      step();
      cnt++;
    end while (!accepted && cnt < 2000);
    tx_if.tx_valid = 1'b0;
    tgt = 0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_pair: no accept after %0d cycles, expected one", cnt);
    end else begin
      tgt = last_accept_n / FRAME_CYC + 1;
    end
  endtask

  task automatic wait_frame(input int f);
    int cnt;
    cnt = 0;
    while (!cap_done[f] && cnt < 2000) begin
      step();
      cnt++;
    end
    if (!cap_done[f]) begin
      checks++;
      errors++;
      $display("FAIL wait_frame: frame %0d not complete, got timeout expected completion", f);
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [63:0]  exp_bits;
  } vec_t;

  vec_t           vecs [4];
  stereo_sample_t b2b  [3];
  logic [63:0]    b2b_exp [3];
  int             acc_n [3];
  int             tf [3];

  initial begin
    int tgt, ta, tb2, tc, f0, idx, cnt;

    vecs[0] = '{16'hFFFF, 16'h8111, 64'hFFFF_0000_8111_0000};
    vecs[1] = '{16'h1234, 16'h5678, 64'h1234_0000_5678_0000};
    vecs[2] = '{16'h8000, 16'h0001, 64'h8000_0000_0001_0000};
    vecs[3] = '{16'h0000, 16'hFFFF, 64'h0000_0000_FFFF_0000};

    b2b[0] = '{l: 16'h1234, r: 16'h5678};
    b2b[1] = '{l: 16'hABCD, r: 16'h0F0F};
    b2b[2] = '{l: 16'h55AA, r: 16'hAA55};
    b2b_exp[0] = 64'h1234_0000_5678_0000;
    b2b_exp[1] = 64'hABCD_0000_0F0F_0000;
    b2b_exp[2] = 64'h55AA_0000_AA55_0000;

    rst             = 1'b1;
    tx_if.tx_valid  = 1'b0;
    tx_if.tx_data_l = '0;
    tx_if.tx_data_r = '0;

    // Reset for three cycles.
    repeat (3) step();
    check("reset_outputs", 64'({sclk, ws, sd_tx, tx_if.tx_ready, underflow}), 64'(5'b00010));
    rst      = 1'b0;
    uf_count = 0;

    // Table-driven pairs; the first is offered during the silent frame 0.
    for (int i = 0; i < 4; i++) begin
      send_pair(vecs[i].l, vecs[i].r, tgt);
      if (i == 0) check("first_pair_frame", 64'(tgt), 64'd1);
      wait_frame(tgt);
      check($sformatf("vector%0d_bits", i), cap_bits[tgt], vecs[i].exp_bits);
      if (i == 0) check("no_underflow_frames0_1", 64'(uf_count), 64'd0);
    end

    // ws edge positions within the frame.
`ifdef I2S_LEFT_JUSTIFIED_EN
    check("ws_rise_bit", 64'(ws_rise_k), 64'd32);
    check("ws_fall_bit", 64'(ws_fall_k), 64'd0);
`else
    check("ws_rise_bit", 64'(ws_rise_k), 64'd31);
    check("ws_fall_bit", 64'(ws_fall_k), 64'd63);
`endif

    // Starve one frame: exactly one underflow pulse, then the next pair follows.
    f0       = n / FRAME_CYC;
    uf_count = 0;
    cnt      = 0;
    while (n < (f0 + 1) * FRAME_CYC + 4 && cnt < 2000) begin
      step();
      cnt++;
    end
    check("underflow_once", 64'(uf_count), 64'd1);
    send_pair(16'hC3A5, 16'h5A3C, tgt);
    check("after_underflow_frame", 64'(tgt), 64'(f0 + 2));
    wait_frame(tgt);
    check("starved_frame_bits", cap_bits[f0+1], 64'h0);
    check("after_underflow_bits", cap_bits[tgt], 64'hC3A5_0000_5A3C_0000);

    // tx_valid held high with a new pair after each accept.
    idx             = 0;
    cnt             = 0;
    tx_if.tx_data_l = b2b[0].l;
    tx_if.tx_data_r = b2b[0].r;
    tx_if.tx_valid  = 1'b1;
    while (idx < 3 && cnt < 4000) begin
      step();
      cnt++;
      if (accepted) begin
        acc_n[idx] = last_accept_n;
        tf[idx]    = last_accept_n / FRAME_CYC + 1;
        idx++;
        if (idx < 3) begin
          tx_if.tx_data_l = b2b[idx].l;
          tx_if.tx_data_r = b2b[idx].r;
        end else begin
          tx_if.tx_valid = 1'b0;
        end
      end
    end
    tx_if.tx_valid = 1'b0;
    check("b2b_accept_count", 64'(idx), 64'd3);
    if (idx == 3) begin
      check("b2b_accept1_phase", 64'(acc_n[1] % FRAME_CYC), 64'd1);
      check("b2b_accept2_phase", 64'(acc_n[2] % FRAME_CYC), 64'd1);
      check("b2b_frame1_next", 64'(tf[1]), 64'(tf[0] + 1));
      check("b2b_frame2_next", 64'(tf[2]), 64'(tf[1] + 1));
      wait_frame(tf[2]);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b_pair%0d_bits", i), cap_bits[tf[i]], b2b_exp[i]);
      end
    end

    // Reset during the right slot while a pair is waiting in the holding register.
    send_pair(16'hDEAD, 16'hBEEF, ta);
    cnt = 0;
    while (n / FRAME_CYC < ta && cnt < 2000) begin
      step();
      cnt++;
    end
    send_pair(16'h7777, 16'h1111, tb2);
    check("held_pair_frame", 64'(tb2), 64'(ta + 1));
    cnt = 0;
    while (!((n / FRAME_CYC == ta) && ((n / DIV) % FRAME_BITS == 48)) && cnt < 2000) begin
      step();
      cnt++;
    end
    rst = 1'b1;
    step();
    check("mid_reset_outputs", 64'({sclk, ws, sd_tx, tx_if.tx_ready, underflow}), 64'(5'b00010));
    rst = 1'b0;
    send_pair(16'h4242, 16'h2424, tc);
    check("post_reset_frame", 64'(tc), 64'd1);
    wait_frame(tc);
    check("post_reset_frame0_silent", cap_bits[0], 64'h0);
    check("post_reset_pair_bits", cap_bits[1], 64'h4242_0000_2424_0000);

    // Randomised traffic against the model, data changing while tx_ready is low.
    for (int c = 0; c < 6 * FRAME_CYC; c++) begin
      tx_if.tx_valid  = ($urandom_range(0, 99) < 3);
      tx_if.tx_data_l = W'($urandom);
      tx_if.tx_data_r = W'($urandom);
      step();
    end
    tx_if.tx_valid = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
